// File: rtl/image_row_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : image_row_reader_pkg
// Purpose : Shared widths and the reader state encoding for the image
//           pipeline row-buffer read side.
// Revision: 1.0  initial release
// ============================================================================
package image_row_reader_pkg;

   // Row buffer address width (depth = 2**ROW_ADDR_W pixels)
   localparam int ROW_ADDR_W = 11;

   // Pixel width (RGB565)
   localparam int PIX_W = 16;

   // Reader control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } reader_state_t;

endpackage : image_row_reader_pkg
`default_nettype wire

// File: rtl/image_row_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : image_row_reader_if
// Purpose : Pixel output stream (valid/ready with end-of-row flag) between
//           the row reader and the display/output pipeline.
// Revision: 1.0  initial release
// ============================================================================
interface image_row_reader_if
   import image_row_reader_pkg::*;
#(
   parameter int DATA_W = PIX_W
) ();

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   // Producer side: drives the pixel and its qualifiers
   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   // Consumer side: accepts pixels
   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface : image_row_reader_if
`default_nettype wire

// File: rtl/image_row_reader_stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module  : stream_skid_fifo
// Purpose : Two-entry FIFO holding {last, data} for the pixel stream. The
//           head entry is presented directly on the output; a push and a pop
//           in the same cycle leave the occupancy unchanged.
// Revision: 1.0  initial release
// ============================================================================
module stream_skid_fifo
   import image_row_reader_pkg::*;
#(
   parameter int WIDTH = PIX_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Head of the FIFO is always visible; storage is cleared on reset so the
   // output data reads as zero after reset.
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

   // A pop is only honoured when an entry exists; a push into a full FIFO is
   // only honoured when the head leaves in the same cycle.
   assign do_pop  = pop & out_valid;
   assign do_push = push & ((count != 2'd2) | do_pop);

   // Storage, pointers and occupancy update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule : stream_skid_fifo
`default_nettype wire

// File: rtl/image_row_reader.sv
`default_nettype none
// ============================================================================
// Module  : image_row_reader
// Purpose : Read side of the image row buffer. On a start pulse, reads one
//           row of pixels through the buffer's port B and presents them as a
//           valid/ready stream with a last flag, one pixel per clock when the
//           consumer is ready.
// Revision: 1.0  initial release
// ============================================================================
module image_row_reader
   import image_row_reader_pkg::*;
#(
   parameter int ADDR_W = ROW_ADDR_W,
   parameter int DATA_W = PIX_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] row_base,
   input  logic [ADDR_W:0]   row_len,
   output logic              busy,
   output logic              done,
   output logic              rd_ce,
   output logic              rd_oce,
   output logic              rd_wre,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   image_row_reader_if.master m
);

   reader_state_t     state;
   reader_state_t     state_nxt;

   logic [ADDR_W:0]   len_q;       // pixel count of the current row
   logic [ADDR_W:0]   issued;      // reads issued so far in this row
   logic              accept;      // start taken in IDLE
   logic              zero_row;    // start taken with an empty row
   logic              row_done;    // final pixel leaves the stream
   logic              issue_last;  // read being issued fetches the final pixel
   logic              pop;         // output handshake

   // One bit per read still travelling through the BRAM pipeline, with the
   // last-pixel tag riding alongside so it lands in the FIFO with its data.
   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_last;

   logic [7:0]        inflight_cnt;
   logic [7:0]        occupancy;   // FIFO entries plus reads in flight, after this cycle's pop
   logic [1:0]        fifo_count;
   logic              fifo_valid;
   logic [DATA_W:0]   fifo_head;

   // Port B is a pure read port with the output register always enabled
   assign rd_oce = 1'b1;
   assign rd_wre = 1'b0;

   assign busy       = (state != IDLE);
   assign pop        = fifo_valid & m.m_ready;
   assign issue_last = (issued == (len_q - (ADDR_W+1)'(1)));

   // Stream outputs come straight from the FIFO head
   assign m.m_valid = fifo_valid;
   assign m.m_data  = fifo_head[DATA_W-1:0];
   assign m.m_last  = fifo_head[DATA_W];

   // Count reads in flight and the resulting buffer pressure. A read is only
   // issued while this stays below the FIFO depth, so every returning pixel
   // is guaranteed a slot.
   always_comb begin
      inflight_cnt = 8'd0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight_cnt = inflight_cnt + 8'(pipe_vld[i]);
      end
      occupancy = 8'(fifo_count) + inflight_cnt - 8'(pop);
   end

   // Next-state and read-issue decisions
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      zero_row  = 1'b0;
      row_done  = 1'b0;
      rd_ce     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (row_len == '0) begin
                  zero_row = 1'b1;
               end else begin
                  state_nxt = READ;
               end
            end
         end
         READ: begin
            if (issued == len_q) begin
               state_nxt = DRAIN;
            end else begin
               rd_ce = (occupancy < 8'd2);
            end
         end
         DRAIN: begin
            if (pop && m.m_last) begin
               state_nxt = IDLE;
               row_done  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Row parameters, read address, issue counter and done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q   <= '0;
         issued  <= '0;
         rd_addr <= '0;
         done    <= 1'b0;
      end else begin
         done <= zero_row | row_done;
         if (accept) begin
            len_q   <= row_len;
            rd_addr <= row_base;
            issued  <= '0;
         end else if (rd_ce) begin
            // Address wraps naturally at the top of the buffer
            rd_addr <= rd_addr + ADDR_W'(1);
            issued  <= issued + (ADDR_W+1)'(1);
         end
      end
   end

   // Track reads through the BRAM latency; the oldest stage feeds the FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld  <= '0;
         pipe_last <= '0;
      end else begin
         pipe_vld[0]  <= rd_ce;
         pipe_last[0] <= rd_ce & issue_last;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
      end
   end

   stream_skid_fifo #(
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pipe_vld[RD_LAT-1]),
      .push_data ({pipe_last[RD_LAT-1], rd_data}),
      .pop       (pop),
      .out_valid (fifo_valid),
      .out_data  (fifo_head),
      .count     (fifo_count)
   );

endmodule : image_row_reader
`default_nettype wire

// File: tb/tb_image_row_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_image_row_reader
// Purpose : Directed bench for image_row_reader with a row buffer model on
//           port B preloaded with address-valued pixels.
// Revision: 1.0  initial release
// ============================================================================
module tb_image_row_reader;
   import image_row_reader_pkg::*;

   localparam int AW    = ROW_ADDR_W;
   localparam int DW    = PIX_W;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] row_base;
   logic [AW:0]   row_len;
   logic          busy;
   logic          done;
   logic          rd_ce;
   logic          rd_oce;
   logic          rd_wre;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   image_row_reader_if #(.DATA_W(DW)) s_if ();

   image_row_reader #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .RD_LAT (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .row_base (row_base),
      .row_len  (row_len),
      .busy     (busy),
      .done     (done),
      .rd_ce    (rd_ce),
      .rd_oce   (rd_oce),
      .rd_wre   (rd_wre),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .m        (s_if)
   );

   always #5 clk = ~clk;

   // Row buffer port B: registered read, data valid the cycle after rd_ce
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (rd_ce) rd_data <= mem[rd_addr];
   end

   // Scoreboard and bookkeeping
   logic [DW:0]   exp_q [$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            outstanding = 0;
   int            done_cnt = 0;
   int            ce_cnt = 0;
   int            pop_cnt = 0;
   int            last_pop_cyc = 0;
   int            prev_pop_cyc = -1;
   int            first_pop_cyc = 0;
   int            start_cyc = 0;
   int            ready_mode = 0;   // 0: always ready, 1: random, 2: never
   bit            zero_mode = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: set ready for the coming edge, then sample and check
   task automatic watch_cycle();
      logic       pop;
      logic [DW:0] e;
      @(negedge clk);
      case (ready_mode)
         0:       s_if.m_ready = 1'b1;
         1:       s_if.m_ready = 1'($urandom_range(0, 1));
         default: s_if.m_ready = 1'b0;
      endcase
      #1;
      cyc++;
      pop = s_if.m_valid & s_if.m_ready;
      if (prev_stall) begin
         check("hold_valid", 32'(s_if.m_valid), 32'd1);
         check("hold_data", 32'(s_if.m_data), 32'(prev_data));
         check("hold_last", 32'(s_if.m_last), 32'(prev_last));
      end
      if (rd_ce) begin
         ce_cnt++;
         check("issue_rule", 32'((outstanding - int'(pop)) < 2), 32'd1);
      end
      if (pop) begin
         check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pix_data", 32'(s_if.m_data), 32'(e[DW-1:0]));
            check("pix_last", 32'(s_if.m_last), 32'(e[DW]));
         end
         if (prev_pop_cyc < 0) first_pop_cyc = cyc;
         else if (ready_mode == 0) check("back_to_back", 32'(cyc - prev_pop_cyc), 32'd1);
         prev_pop_cyc = cyc;
         pop_cnt++;
         if (s_if.m_last) last_pop_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         if (!zero_mode) check("done_after_last", 32'(cyc - last_pop_cyc), 32'd1);
      end
      outstanding = outstanding + int'(rd_ce) - int'(pop);
      prev_stall  = s_if.m_valid & ~s_if.m_ready;
      prev_data   = s_if.m_data;
      prev_last   = s_if.m_last;
   endtask

   task automatic start_row(input int base, input int len);
      logic [DW:0] e;
      row_base = AW'(base);
      row_len  = (AW+1)'(len);
      start    = 1'b1;
      for (int i = 0; i < len; i++) begin
         e[DW]       = (i == len - 1);
         e[DW-1:0]   = DW'((base + i) % DEPTH);
         exp_q.push_back(e);
      end
      prev_pop_cyc = -1;
      zero_mode    = (len == 0);
      watch_cycle();
      start_cyc = cyc;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         watch_cycle();
         n++;
      end
      check("done_seen", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int p0;
      int c0;
      int d0;
      int n;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      reset       = 1'b1;
      start       = 1'b0;
      row_base    = '0;
      row_len     = '0;
      s_if.m_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_ce", 32'(rd_ce), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_m_valid", 32'(s_if.m_valid), 32'd0);
      check("rst_m_data", 32'(s_if.m_data), 32'd0);
      check("rst_m_last", 32'(s_if.m_last), 32'd0);
      check("rd_oce_const", 32'(rd_oce), 32'd1);
      check("rd_wre_const", 32'(rd_wre), 32'd0);
      reset = 1'b0;

      // 1: base 0, 8 pixels, always ready
      ready_mode = 0;
      p0 = pop_cnt;
      start_row(0, 8);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(50);
      check("t1_first_latency", 32'(first_pop_cyc - start_cyc), 32'd2);
      check("t1_pop_count", 32'(pop_cnt - p0), 32'd8);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
      check("t1_busy_end", 32'(busy), 32'd0);

      // 2: wrap around the top of the buffer
      start_row(2044, 8);
      wait_done(50);
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // 3: 640 pixels under random backpressure, wrapping
      ready_mode = 1;
      p0 = pop_cnt;
      start_row(1700, 640);
      wait_done(5000);
      check("t3_pop_count", 32'(pop_cnt - p0), 32'd640);
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // 4a: empty row
      ready_mode = 0;
      c0 = ce_cnt;
      d0 = done_cnt;
      start_row(5, 0);
      check("t4_busy_start", 32'(busy), 32'd0);
      repeat (4) begin
         watch_cycle();
         check("t4_busy", 32'(busy), 32'd0);
         check("t4_valid", 32'(s_if.m_valid), 32'd0);
      end
      check("t4_no_reads", 32'(ce_cnt - c0), 32'd0);
      check("t4_one_done", 32'(done_cnt - d0), 32'd1);

      // 4b: start while busy is ignored
      p0 = pop_cnt;
      start_row(100, 16);
      repeat (3) watch_cycle();
      check("t4_busy_mid", 32'(busy), 32'd1);
      row_base = AW'(500);
      row_len  = (AW+1)'(3);
      start    = 1'b1;
      watch_cycle();
      start    = 1'b0;
      wait_done(100);
      check("t4_pop_count", 32'(pop_cnt - p0), 32'd16);
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
      d0 = done_cnt;
      repeat (5) watch_cycle();
      check("t4_no_extra_done", 32'(done_cnt - d0), 32'd0);
      check("t4_no_extra_pix", 32'(pop_cnt - p0), 32'd16);

      // 5: reset after 5 of 16 pixels
      p0 = pop_cnt;
      start_row(0, 16);
      n = 0;
      while ((pop_cnt - p0) < 5 && n < 50) begin
         watch_cycle();
         n++;
      end
      check("t5_five_popped", 32'(pop_cnt - p0), 32'd5);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_rd_ce", 32'(rd_ce), 32'd0);
      check("t5_rd_addr", 32'(rd_addr), 32'd0);
      check("t5_m_valid", 32'(s_if.m_valid), 32'd0);
      check("t5_m_data", 32'(s_if.m_data), 32'd0);
      check("t5_m_last", 32'(s_if.m_last), 32'd0);
      exp_q.delete();
      outstanding = 0;
      prev_stall  = 0;
      d0 = done_cnt;
      repeat (3) watch_cycle();
      reset = 1'b0;
      repeat (3) watch_cycle();
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      start_row(20, 4);
      wait_done(50);
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // 6: consumer stalled for 10 cycles, then released
      ready_mode = 2;
      c0 = ce_cnt;
      start_row(300, 4);
      repeat (10) watch_cycle();
      check("t6_reads_in_stall", 32'(ce_cnt - c0), 32'd2);
      check("t6_valid_in_stall", 32'(s_if.m_valid), 32'd1);
      ready_mode = 0;
      wait_done(50);
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
      check("t6_total_reads", 32'(ce_cnt - c0), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_image_row_reader
`default_nettype wire
